// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
// Shares one APB3 master port among NUM_REQ local requesters using round-robin
// arbitration. Each transfer runs IDLE -> SETUP -> ACCESS -> IDLE, and the
// completion (read data + error) is returned to the requester that won.
//
// Ports
//   PCLK, PRESET           clock (rising edge) and synchronous active-high reset
//   req_valid/req_write    per-requester request and direction (1 = write)
//   req_addr/req_wdata     packed per-requester address / write data
//   req_ready              1-cycle accept pulse to the winner (during SETUP)
//   rsp_valid              1-cycle completion pulse to the winner
//   rsp_rdata/rsp_err      response data / error, held until next completion
//   PSEL..PWDATA           APB master outputs (all registered)
//   PRDATA/PREADY/PSLVERR  APB slave inputs
//
// Optional feature
//   APB_ARB_TIMEOUT_EN     when defined, an ACCESS phase that sees PREADY=0 for
//                          TIMEOUT_CYCLES cycles is terminated with rsp_err=1
//                          and rsp_rdata=0. When undefined ACCESS waits forever.
// -----------------------------------------------------------------------------
module apb_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [IDX_W-1:0]   owner, owner_n;
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic               timeout_hit;

    logic [NUM_REQ-1:0] req_ready_n, rsp_valid_n;
    logic [DATA_W-1:0]  rsp_rdata_n;
    logic               rsp_err_n;
    logic               psel_n, penable_n, pwrite_n;
    logic [ADDR_W-1:0]  paddr_n;
    logic [DATA_W-1:0]  pwdata_n;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    // Unpack the flat request buses so they can be indexed by requester number.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Counts ACCESS cycles without PREADY; held at zero outside ACCESS so it
    // starts clean on every entry. Hit fires on the TIMEOUT_CYCLES-th wait cycle.
    always_ff @(posedge PCLK) begin
        if (PRESET || state != ST_ACCESS) begin
            wait_cnt <= '0;
        end else if (!PREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (int'(wait_cnt) == TIMEOUT_CYCLES - 1);
`else
    assign timeout_hit = 1'b0;
`endif

    // Round-robin pick: first valid requester scanning upward from ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic. Every output is registered, so this
    // block computes the value each output will take after the coming edge.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        owner_n     = owner;
        psel_n      = PSEL;
        penable_n   = PENABLE;
        pwrite_n    = PWRITE;
        paddr_n     = PADDR;
        pwdata_n    = PWDATA;
        req_ready_n = '0;
        rsp_valid_n = '0;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;

        case (state)
            ST_IDLE: begin
                psel_n    = 1'b0;
                penable_n = 1'b0;
                if (grant_found) begin
                    state_n                = ST_SETUP;
                    owner_n                = grant_idx;
                    ptr_n                  = IDX_W'((int'(grant_idx) + 1) % NUM_REQ);
                    psel_n                 = 1'b1;
                    pwrite_n               = req_write[grant_idx];
                    paddr_n                = addr_arr[grant_idx];
                    pwdata_n               = wdata_arr[grant_idx];
                    req_ready_n[grant_idx] = 1'b1;
                end
            end
            ST_SETUP: begin
                state_n   = ST_ACCESS;
                penable_n = 1'b1;
            end
            ST_ACCESS: begin
                if (PREADY || timeout_hit) begin
                    state_n            = ST_IDLE;
                    psel_n             = 1'b0;
                    penable_n          = 1'b0;
                    rsp_valid_n[owner] = 1'b1;
                    if (PREADY) begin
                        rsp_rdata_n = PWRITE ? '0 : PRDATA;
                        rsp_err_n   = PSLVERR;
                    end else begin
                        rsp_rdata_n = '0;
                        rsp_err_n   = 1'b1;
                    end
                end
            end
            default: begin
                state_n   = ST_IDLE;
                psel_n    = 1'b0;
                penable_n = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer without a response.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            owner     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            owner     <= owner_n;
            PSEL      <= psel_n;
            PENABLE   <= penable_n;
            PWRITE    <= pwrite_n;
            PADDR     <= paddr_n;
            PWDATA    <= pwdata_n;
            req_ready <= req_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arbiter
// Self-checking bench for apb_master_arbiter (NUM_REQ=4, 32-bit buses).
// Expected grants and responses are queued when requests are driven and
// popped when the DUT produces req_ready / rsp_valid.
// -----------------------------------------------------------------------------
module tb_apb_master_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic                      PCLK = 1'b0;
    logic                      PRESET;
    logic [NUM_REQ-1:0]        req_valid, req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready, rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      PSEL, PENABLE, PWRITE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA, PRDATA;
    logic                      PREADY, PSLVERR;

    logic                      use_addr_data;
    logic [DATA_W-1:0]         prdata_val;

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    rsp_t exp_q[$];
    int   grant_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Slave read data: either a fixed value or an address-derived pattern.
    assign PRDATA = use_addr_data ? (PADDR ^ 32'hC0DE_0000) : prdata_val;

    always #5 PCLK = ~PCLK;

    apb_master_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic applyStimulus(input int i, input logic wr,
                                 input logic [31:0] a, input logic [31:0] d);
        req_write[i]           = wr;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic test_reset();
        PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PREADY = 1'b0; PSLVERR = 1'b0; use_addr_data = 1'b0; prdata_val = '0;
        repeat (2) @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
            failures++; $display("[TB] FAIL reset_ctrl got=%b exp=000", {PSEL, PENABLE, PWRITE});
        end
        checks++;
        if (req_ready !== 4'b0 || rsp_valid !== 4'b0) begin
            failures++; $display("[TB] FAIL reset_hs ready=%b valid=%b exp=0", req_ready, rsp_valid);
        end
        checks++;
        if (PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_data paddr=%h pwdata=%h rdata=%h err=%b exp=0",
                                 PADDR, PWDATA, rsp_rdata, rsp_err);
        end
        PRESET = 1'b0;
    endtask

    task automatic test_single_read();
        rsp_t e;
        @(negedge PCLK);
        applyStimulus(0, 1'b0, 32'h10, 32'h0);
        req_valid = 4'b0001; PREADY = 1'b1; PSLVERR = 1'b0; prdata_val = 32'hA5A5_0001;
        exp_q.push_back('{idx: 0, rdata: 32'hA5A5_0001, err: 1'b0});
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE} !== 2'b10 || req_ready !== 4'b0001) begin
            failures++; $display("[TB] FAIL rd_setup sel/en=%b ready=%b exp=10/0001", {PSEL, PENABLE}, req_ready);
        end
        checks++;
        if (PADDR !== 32'h10 || PWRITE !== 1'b0) begin
            failures++; $display("[TB] FAIL rd_addr paddr=%h pwrite=%b exp=10/0", PADDR, PWRITE);
        end
        req_valid = 4'b0000;
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE} !== 2'b11 || req_ready !== 4'b0 || rsp_valid !== 4'b0) begin
            failures++; $display("[TB] FAIL rd_access sel/en=%b ready=%b valid=%b exp=11/0/0",
                                 {PSEL, PENABLE}, req_ready, rsp_valid);
        end
        @(negedge PCLK);
        e = exp_q.pop_front();
        checks++;
        if ({PSEL, PENABLE} !== 2'b00 || rsp_valid !== (4'b0001 << e.idx)) begin
            failures++; $display("[TB] FAIL rd_done sel/en=%b valid=%b exp=00/%b",
                                 {PSEL, PENABLE}, rsp_valid, 4'b0001 << e.idx);
        end
        checks++;
        if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            failures++; $display("[TB] FAIL rd_data rdata=%h err=%b exp=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
        end
    endtask

    task automatic test_round_robin();
        rsp_t e;
        int   g, grants, rsps, last_rsp_cyc;
        @(negedge PCLK); PRESET = 1'b1;
        @(negedge PCLK); PRESET = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b0, 32'h100 * i + 32'h40, 32'h0);
        use_addr_data = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0; req_valid = 4'hF;
        grant_q = '{0, 1, 2, 3, 0};
        foreach (grant_q[k])
            exp_q.push_back('{idx: grant_q[k], rdata: (32'h100 * grant_q[k] + 32'h40) ^ 32'hC0DE_0000, err: 1'b0});
        grants = 0; rsps = 0; last_rsp_cyc = -10;
        for (int cyc = 0; cyc < 60 && rsps < 5; cyc++) begin
            @(negedge PCLK);
            if (req_ready !== 4'b0000) begin
                checks++;
                if (grant_q.size() == 0) begin
                    failures++; $display("[TB] FAIL rr_extra_grant ready=%b exp=none", req_ready);
                end else begin
                    g = grant_q.pop_front();
                    if (req_ready !== (4'b0001 << g)) begin
                        failures++; $display("[TB] FAIL rr_grant ready=%b exp=%b", req_ready, 4'b0001 << g);
                    end
                end
                if (grants > 0) begin
                    checks++;
                    if (cyc - last_rsp_cyc != 1) begin
                        failures++; $display("[TB] FAIL rr_gap idle_cycles=%0d exp=1", cyc - last_rsp_cyc);
                    end
                end
                grants++;
                if (grants == 5) req_valid = 4'b0000;
            end
            if (rsp_valid !== 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("[TB] FAIL rr_extra_rsp valid=%b exp=none", rsp_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (PSEL !== 1'b0 || rsp_valid !== (4'b0001 << e.idx) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        failures++; $display("[TB] FAIL rr_rsp psel=%b valid=%b rdata=%h err=%b exp=0/%b/%h/%b",
                                             PSEL, rsp_valid, rsp_rdata, rsp_err, 4'b0001 << e.idx, e.rdata, e.err);
                    end
                end
                rsps++; last_rsp_cyc = cyc;
            end
        end
        checks++;
        if (grants != 5 || rsps != 5) begin
            failures++; $display("[TB] FAIL rr_count grants=%0d rsps=%0d exp=5/5", grants, rsps);
        end
        use_addr_data = 1'b0;
    endtask

    task automatic test_write_wait();
        rsp_t e;
        @(negedge PCLK);
        applyStimulus(2, 1'b1, 32'h20, 32'hDEAD_BEEF);
        req_valid = 4'b0100; PREADY = 1'b0; PSLVERR = 1'b0; prdata_val = 32'hFFFF_FFFF;
        exp_q.push_back('{idx: 2, rdata: 32'h0, err: 1'b0});
        @(negedge PCLK);
        checks++;
        if (req_ready !== 4'b0100 || {PSEL, PENABLE} !== 2'b10) begin
            failures++; $display("[TB] FAIL wr_setup ready=%b sel/en=%b exp=0100/10", req_ready, {PSEL, PENABLE});
        end
        req_valid = 4'b0000;
        applyStimulus(2, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge PCLK);
            checks++;
            if ({PSEL, PENABLE, PWRITE} !== 3'b111 || PADDR !== 32'h20 || PWDATA !== 32'hDEAD_BEEF || rsp_valid !== 4'b0) begin
                failures++; $display("[TB] FAIL wr_access%0d ctl=%b paddr=%h pwdata=%h valid=%b exp=111/20/deadbeef/0",
                                     c, {PSEL, PENABLE, PWRITE}, PADDR, PWDATA, rsp_valid);
            end
            PREADY  = (c == 3);
            PSLVERR = (c != 3);
        end
        @(negedge PCLK);
        e = exp_q.pop_front();
        checks++;
        if (PSEL !== 1'b0 || rsp_valid !== (4'b0001 << e.idx) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            failures++; $display("[TB] FAIL wr_done psel=%b valid=%b rdata=%h err=%b exp=0/%b/%h/%b",
                                 PSEL, rsp_valid, rsp_rdata, rsp_err, 4'b0001 << e.idx, e.rdata, e.err);
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
    endtask

    task automatic test_slverr();
        rsp_t e;
        @(negedge PCLK);
        applyStimulus(3, 1'b0, 32'h30, 32'h0);
        req_valid = 4'b1000; PREADY = 1'b1; PSLVERR = 1'b1; prdata_val = 32'h1234_5678;
        exp_q.push_back('{idx: 3, rdata: 32'h1234_5678, err: 1'b1});
        @(negedge PCLK);
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++; $display("[TB] FAIL err_grant ready=%b exp=1000", req_ready);
        end
        req_valid = 4'b0000;
        @(negedge PCLK);
        @(negedge PCLK);
        e = exp_q.pop_front();
        checks++;
        if (rsp_valid !== (4'b0001 << e.idx) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            failures++; $display("[TB] FAIL err_rsp valid=%b rdata=%h err=%b exp=%b/%h/%b",
                                 rsp_valid, rsp_rdata, rsp_err, 4'b0001 << e.idx, e.rdata, e.err);
        end
        PSLVERR = 1'b0; PREADY = 1'b0;
        @(negedge PCLK);
        checks++;
        if (rsp_valid !== 4'b0 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            failures++; $display("[TB] FAIL err_hold valid=%b rdata=%h err=%b exp=0/%h/%b",
                                 rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
        end
    endtask

    task automatic test_reset_mid();
        rsp_t e;
        int   g, rsps;
        @(negedge PCLK);
        applyStimulus(2, 1'b0, 32'h50, 32'h0);
        req_valid = 4'b0100; PREADY = 1'b0;
        @(negedge PCLK);
        req_valid = 4'b0000;
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            failures++; $display("[TB] FAIL rst_pre sel/en=%b exp=11", {PSEL, PENABLE});
        end
        PRESET = 1'b1; PREADY = 1'b1;
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE} !== 2'b00 || rsp_valid !== 4'b0) begin
            failures++; $display("[TB] FAIL rst_abort sel/en=%b valid=%b exp=00/0", {PSEL, PENABLE}, rsp_valid);
        end
        PRESET = 1'b0;
        @(negedge PCLK);
        checks++;
        if (PSEL !== 1'b0 || rsp_valid !== 4'b0) begin
            failures++; $display("[TB] FAIL rst_quiet psel=%b valid=%b exp=0/0", PSEL, rsp_valid);
        end
        applyStimulus(2, 1'b0, 32'h60, 32'h0);
        applyStimulus(3, 1'b0, 32'h70, 32'h0);
        use_addr_data = 1'b1; req_valid = 4'b1100;
        grant_q = '{2, 3};
        exp_q.push_back('{idx: 2, rdata: 32'h60 ^ 32'hC0DE_0000, err: 1'b0});
        exp_q.push_back('{idx: 3, rdata: 32'h70 ^ 32'hC0DE_0000, err: 1'b0});
        rsps = 0;
        for (int cyc = 0; cyc < 30 && rsps < 2; cyc++) begin
            @(negedge PCLK);
            if (req_ready !== 4'b0000) begin
                checks++;
                g = (grant_q.size() != 0) ? grant_q.pop_front() : -1;
                if (g < 0 || req_ready !== (4'b0001 << g)) begin
                    failures++; $display("[TB] FAIL rst_grant ready=%b exp_idx=%0d", req_ready, g);
                end
                req_valid = req_valid & ~req_ready;
            end
            if (rsp_valid !== 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("[TB] FAIL rst_extra_rsp valid=%b exp=none", rsp_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_valid !== (4'b0001 << e.idx) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                        failures++; $display("[TB] FAIL rst_rsp valid=%b rdata=%h err=%b exp=%b/%h/%b",
                                             rsp_valid, rsp_rdata, rsp_err, 4'b0001 << e.idx, e.rdata, e.err);
                    end
                end
                rsps++;
            end
        end
        checks++;
        if (rsps != 2) begin
            failures++; $display("[TB] FAIL rst_count rsps=%0d exp=2", rsps);
        end
        req_valid = 4'b0000; use_addr_data = 1'b0; PREADY = 1'b0;
    endtask

    task automatic test_timeout();
        @(negedge PCLK);
        applyStimulus(1, 1'b0, 32'h80, 32'h0);
        req_valid = 4'b0010; PREADY = 1'b0; PSLVERR = 1'b0; prdata_val = 32'hBAD0_BAD0;
        @(negedge PCLK);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("[TB] FAIL to_grant ready=%b exp=0010", req_ready);
        end
        req_valid = 4'b0000;
`ifdef APB_ARB_TIMEOUT_EN
        begin
            rsp_t e;
            exp_q.push_back('{idx: 1, rdata: 32'h0, err: 1'b1});
            for (int c = 0; c < 16; c++) begin
                @(negedge PCLK);
                checks++;
                if ({PSEL, PENABLE} !== 2'b11 || rsp_valid !== 4'b0) begin
                    failures++; $display("[TB] FAIL to_wait%0d sel/en=%b valid=%b exp=11/0", c, {PSEL, PENABLE}, rsp_valid);
                end
            end
            @(negedge PCLK);
            e = exp_q.pop_front();
            checks++;
            if ({PSEL, PENABLE} !== 2'b00 || rsp_valid !== (4'b0001 << e.idx) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                failures++; $display("[TB] FAIL to_rsp sel/en=%b valid=%b rdata=%h err=%b exp=00/%b/%h/%b",
                                     {PSEL, PENABLE}, rsp_valid, rsp_rdata, rsp_err, 4'b0001 << e.idx, e.rdata, e.err);
            end
        end
`else
        for (int c = 0; c < 100; c++) begin
            @(negedge PCLK);
            checks++;
            if ({PSEL, PENABLE} !== 2'b11 || rsp_valid !== 4'b0) begin
                failures++; $display("[TB] FAIL to_stuck%0d sel/en=%b valid=%b exp=11/0", c, {PSEL, PENABLE}, rsp_valid);
            end
        end
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_wait();
        test_slverr();
        test_reset_mid();
        test_timeout();
        checks++;
        if (exp_q.size() != 0 || grant_q.size() != 0) begin
            failures++; $display("[TB] FAIL leftover exp_rsp=%0d exp_grant=%0d exp=0/0", exp_q.size(), grant_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog time_limit reached");
        $fatal(1);
    end

endmodule
